// File: rtl/adpcm_pkg.sv
// Shared widths and UART state encoding for the ADPCM serial output stage.
package adpcm_pkg;
    localparam int ADPCM_CODE_W   = 4;
    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_e;
endpackage

// File: rtl/adpcm_byte_fifo.sv
// Small synchronous byte FIFO; head entry is readable combinationally so the
// transmitter can load it in the same cycle it pops.
module adpcm_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign full  = (level_q == (AW+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        pop_ok   = pop && !empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        level_d  = level_q;
        if (push_ok && !pop_ok) begin
            level_d = level_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end
endmodule

// File: rtl/adpcm_uart_tx.sv
// Packs ADPCM code pairs into bytes (first code in the low nibble), queues
// them and sends each as an 8N1 UART frame on tx.
module adpcm_uart_tx
    import adpcm_pkg::*;
#(
    parameter int CLK_DIV    = 104,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          code_valid,
    input  logic [ADPCM_CODE_W-1:0]       code,
    input  logic                          flush,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);

    uart_state_e               state_q, state_d;
    logic [BAUD_W-1:0]         baud_q, baud_d;
    logic [BIT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      tx_q, tx_d;
    logic                      half_q, half_d;
    logic [ADPCM_CODE_W-1:0]   hold_q, hold_d;
    logic                      overflow_q, overflow_d;

    logic                      push_req;
    logic [UART_DATA_BITS-1:0] push_byte;
    logic                      fifo_pop, fifo_full, fifo_empty, bit_end;
    logic [UART_DATA_BITS-1:0] fifo_dout;

    adpcm_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_req),
        .din   (push_byte),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Nibble packer: a code strobe always takes priority over flush.
    always_comb begin
        half_d    = half_q;
        hold_d    = hold_q;
        push_req  = 1'b0;
        push_byte = {code, hold_q};
        if (code_valid) begin
            if (half_q) begin
                push_req = 1'b1;
                half_d   = 1'b0;
            end else begin
                hold_d = code;
                half_d = 1'b1;
            end
        end else if (flush && half_q) begin
            push_req  = 1'b1;
            push_byte = {{ADPCM_CODE_W{1'b0}}, hold_q};
            half_d    = 1'b0;
        end
        overflow_d = overflow_q | (push_req && fifo_full && !fifo_pop);
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        fifo_pop  = 1'b0;
        bit_end   = (baud_q == BAUD_W'(CLK_DIV - 1));
        if (state_q != IDLE) begin
            baud_d = bit_end ? '0 : baud_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == BIT_W'(UART_DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // tx is decoded from the next state so the pin changes with the state register.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            half_q     <= 1'b0;
            hold_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            half_q     <= half_d;
            hold_q     <= hold_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx       = tx_q;
    assign overflow = overflow_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;
endmodule
